// File: rtl/mux_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_pkg
// Brief    : Shared constants, state type and helpers for mux_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Requester index successor; the 3-bit add wraps 7 -> 0 naturally.
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
        return v + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter_if
// Brief    : Requester-side and output-side handshake bundle of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mux_rr_arbiter_if #(
    parameter int DATAWIDTH = 8
);
    import mux_arb_pkg::*;

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0][DATAWIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                req_last;
    logic [NUM_REQ-1:0]                req_ready;
    logic                              out_valid;
    logic [DATAWIDTH-1:0]              out_data;
    logic                              out_last;
    logic [SEL_W-1:0]                  out_src;
    logic                              out_ready;
    logic                              busy;

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, out_src, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, out_src, busy
    );

endinterface
`default_nettype wire

// File: rtl/mux_8to1.sv
`default_nettype none
// ============================================================================
// Module   : mux_8to1
// Brief    : Plain 8-input combinational selector of WIDTH-bit words.
// Revision : 1.0 - initial release
// ============================================================================
module mux_8to1 #(
    parameter int WIDTH = 8
) (
    input  wire logic [7:0][WIDTH-1:0] din,
    input  wire logic [2:0]            sel,
    output logic      [WIDTH-1:0]      dout
);

    assign dout = din[sel];

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Brief    : Finds the first set request at or above ptr, wrapping 7 -> 0.
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker
    import mux_arb_pkg::*;
(
    input  wire logic [NUM_REQ-1:0] req,
    input  wire logic [SEL_W-1:0]   ptr,
    output logic                    found,
    output logic [SEL_W-1:0]        idx
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [SEL_W-1:0]     pos;

    // Rotating right by ptr puts the highest-priority requester at bit 0.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: NUM_REQ];

    always_comb begin
        pos = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pos = SEL_W'(i);
            end
        end
    end

    assign idx   = pos + ptr;
    assign found = |req;

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter
// Brief    : Packet-locked round-robin arbiter feeding one registered stream.
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mux_rr_arbiter_if.slave     bus
);

    localparam logic [0:0] ST_IDLE   = 1'(IDLE);
    localparam logic [0:0] ST_LOCKED = 1'(LOCKED);

    logic [0:0]           state_q,     state_d;
    logic [SEL_W-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [SEL_W-1:0]     grant_idx_q, grant_idx_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATAWIDTH-1:0] out_data_q,  out_data_d;
    logic                 out_last_q,  out_last_d;
    logic [SEL_W-1:0]     out_src_q,   out_src_d;

    logic                 pick_found;
    logic [SEL_W-1:0]     pick_idx;
    logic [DATAWIDTH-1:0] sel_data;
    logic                 sel_last;
    logic                 sel_valid;
    logic                 locked;
    logic                 accept;
    logic                 xfer;
    logic [NUM_REQ-1:0]   ready_vec;

    rr_picker u_picker (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    mux_8to1 #(.WIDTH(DATAWIDTH)) u_data_mux (
        .din  (bus.req_data),
        .sel  (grant_idx_q),
        .dout (sel_data)
    );

    mux_8to1 #(.WIDTH(1)) u_last_mux (
        .din  (bus.req_last),
        .sel  (grant_idx_q),
        .dout (sel_last)
    );

    assign sel_valid = bus.req_valid[grant_idx_q];
    assign locked    = (state_q == ST_LOCKED);
    // Output slot is free when empty or being drained this cycle.
    assign accept    = !out_valid_q || bus.out_ready;
    assign xfer      = locked && sel_valid && accept;

    always_comb begin
        ready_vec = '0;
        if (locked) begin
            ready_vec[grant_idx_q] = accept;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d     = ST_LOCKED;
                    grant_idx_d = pick_idx;
                end
            end
            ST_LOCKED: begin
                if (xfer && sel_last) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = wrap_inc(grant_idx_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_src_d   = grant_idx_q;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_src   = out_src_q;
    assign bus.busy      = locked;

endmodule
`default_nettype wire
